// File: rtl/leading_zero_normalizer.sv
// ============================================================================
// leading_zero_normalizer
//
// Counts leading zeros, leading ones or trailing zeros of an operand and
// shifts the operand by that count. The result is zero-filled: it is shifted
// left for the leading modes and right for the trailing mode. The count is
// built by a binary segment tree that is spread over STAGES register ranks.
// Each rank has a valid bit, and an elastic valid/ready handshake lets empty
// ranks (bubbles) fill even while the output is stalled.
//
// Parameters
//   WIDTH   operand width, 2..64
//   STAGES  pipeline depth (register ranks), 1..4
//   CW      count width, $clog2(WIDTH)+1
//
// Ports
//   clock       rising-edge clock
//   resetN      asynchronous active-low reset
//   inValid     upstream offers operand/mode
//   inReady     block can accept this cycle
//   operand     value to scan
//   mode        00 lead zeros, 01 lead ones, 10 trail zeros, 11 as 00
//   outValid    result registers hold a valid result
//   outReady    downstream accepts the result
//   count       number of matching digits
//   normalized  operand shifted by count
//   allMatch    every operand bit matched (count == WIDTH)
// ============================================================================
module leading_zero_normalizer #(
    parameter  int WIDTH  = 24,
    parameter  int STAGES = 2,
    localparam int CW     = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] operand,
    input  logic [1:0]       mode,
    output logic             outValid,
    input  logic             outReady,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] normalized,
    output logic             allMatch
);

    // Segment tree geometry: operand padded up to SEGS = 2**LVLS one-bit leaves.
    localparam int LVLS = $clog2(WIDTH);
    localparam int SEGS = 1 << LVLS;
    localparam int LPS  = (LVLS + STAGES - 1) / STAGES;

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("leading_zero_normalizer: STAGES must be 1..4");
    end
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("leading_zero_normalizer: WIDTH must be 2..64");
    end

    // First tree level combined by stage s.
    function automatic int lvl_lo(input int s);
        return (s * LPS < LVLS) ? s * LPS : LVLS;
    endfunction

    // One past the last tree level combined by stage s.
    function automatic int lvl_hi(input int s);
        return ((s + 1) * LPS < LVLS) ? (s + 1) * LPS : LVLS;
    endfunction

    // Handshake
    logic [STAGES:0]   stage_ready_s;
    logic [STAGES-1:0] up_valid_s;
    logic [STAGES-1:0] load_s;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;

    // Mode decode at the input
    logic              ones_in_s;
    logic              trail_in_s;
    logic              digit_s;

    // Per-stage tree state after the stage's own combine levels
    logic [CW-1:0]     lvl_s       [STAGES][SEGS];
    logic [WIDTH-1:0]  stg_op_s    [STAGES];
    logic              stg_trail_s [STAGES];

    // Inter-stage registers (the last rank registers results instead)
    logic [CW-1:0]     seg_q   [STAGES][SEGS];
    logic [CW-1:0]     seg_d   [STAGES][SEGS];
    logic [WIDTH-1:0]  op_q    [STAGES];
    logic [WIDTH-1:0]  op_d    [STAGES];
    logic              trail_q [STAGES];
    logic              trail_d [STAGES];

    // Result registers
    logic [CW-1:0]     fin_cnt_s;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [WIDTH-1:0]  norm_q;
    logic [WIDTH-1:0]  norm_d;
    logic              all_q;
    logic              all_d;

    assign ones_in_s  = (mode == 2'b01);
    assign trail_in_s = (mode == 2'b10);

    // Ready chain from the output back to the input; an empty rank is always ready.
    always_comb begin
        stage_ready_s         = '0;
        stage_ready_s[STAGES] = outReady;
        for (int s = STAGES - 1; s >= 0; s--) begin
            stage_ready_s[s] = ~valid_q[s] | stage_ready_s[s+1];
        end
    end

    // Held low during reset so nothing is accepted until the first edge after release.
    assign inReady = resetN & stage_ready_s[0];

    // Valid propagation: a ready rank takes whatever its upstream offers.
    always_comb begin
        up_valid_s    = '0;
        up_valid_s[0] = inValid & inReady;
        for (int s = 1; s < STAGES; s++) begin
            up_valid_s[s] = valid_q[s-1];
        end
        load_s  = stage_ready_s[STAGES-1:0] & up_valid_s;
        valid_d = valid_q;
        for (int s = 0; s < STAGES; s++) begin
            if (stage_ready_s[s]) begin
                valid_d[s] = up_valid_s[s];
            end else begin
                valid_d[s] = valid_q[s];
            end
        end
    end

    // Stage inputs: rank 0 sees the raw operand, later ranks see the previous registers.
    always_comb begin
        stg_op_s[0]    = operand;
        stg_trail_s[0] = trail_in_s;
        for (int s = 1; s < STAGES; s++) begin
            stg_op_s[s]    = op_q[s-1];
            stg_trail_s[s] = trail_q[s-1];
        end
    end

    // Segment tree. A segment's value is the run of matching digits from its
    // scan-start end. The value is capped at the segment width, so bit k set at
    // level k means the whole segment matched and the run continues into the
    // next segment. Leaves past WIDTH are zero, so they stop the run and keep
    // the count <= WIDTH.
    always_comb begin
        digit_s = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            for (int j = 0; j < SEGS; j++) begin
                lvl_s[s][j] = '0;
            end
        end
        // Leaf j is the j-th bit in scan order (MSB-first, or LSB-first when trailing).
        for (int j = 0; j < WIDTH; j++) begin
            if (trail_in_s) begin
                digit_s = operand[j];
            end else begin
                digit_s = operand[WIDTH-1-j];
            end
            if (ones_in_s) begin
                lvl_s[0][j] = {{(CW-1){1'b0}}, digit_s};
            end else begin
                lvl_s[0][j] = {{(CW-1){1'b0}}, ~digit_s};
            end
        end
        for (int s = 1; s < STAGES; s++) begin
            for (int j = 0; j < SEGS; j++) begin
                lvl_s[s][j] = seg_q[s-1][j];
            end
        end
        // In-place pairwise combine; entry j is written only after 2j and 2j+1 are read.
        for (int s = 0; s < STAGES; s++) begin
            for (int k = lvl_lo(s); k < lvl_hi(s); k++) begin
                for (int j = 0; j < (SEGS >> (k + 1)); j++) begin
                    if (lvl_s[s][2*j][k]) begin
                        lvl_s[s][j] = lvl_s[s][2*j] + lvl_s[s][2*j+1];
                    end else begin
                        lvl_s[s][j] = lvl_s[s][2*j];
                    end
                end
            end
        end
    end

    // Next-state for the datapath registers: load on accept, otherwise hold.
    always_comb begin
        seg_d     = seg_q;
        op_d      = op_q;
        trail_d   = trail_q;
        count_d   = count_q;
        norm_d    = norm_q;
        all_d     = all_q;
        fin_cnt_s = lvl_s[STAGES-1][0];
        for (int s = 0; s < STAGES - 1; s++) begin
            if (load_s[s]) begin
                for (int j = 0; j < SEGS; j++) begin
                    seg_d[s][j] = lvl_s[s][j];
                end
                op_d[s]    = stg_op_s[s];
                trail_d[s] = stg_trail_s[s];
            end else begin
                op_d[s]    = op_q[s];
                trail_d[s] = trail_q[s];
            end
        end
        // The last rank finishes the tree and applies the shift.
        if (load_s[STAGES-1]) begin
            count_d = fin_cnt_s;
            if (stg_trail_s[STAGES-1]) begin
                norm_d = stg_op_s[STAGES-1] >> fin_cnt_s;
            end else begin
                norm_d = stg_op_s[STAGES-1] << fin_cnt_s;
            end
            all_d = (fin_cnt_s == CW'(WIDTH));
        end else begin
            count_d = count_q;
            norm_d  = norm_q;
            all_d   = all_q;
        end
    end

    // State registers; reset empties every rank and zeroes the visible results.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            valid_q <= '0;
            count_q <= '0;
            norm_q  <= '0;
            all_q   <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                op_q[s]    <= '0;
                trail_q[s] <= 1'b0;
                for (int j = 0; j < SEGS; j++) begin
                    seg_q[s][j] <= '0;
                end
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            norm_q  <= norm_d;
            all_q   <= all_d;
            op_q    <= op_d;
            trail_q <= trail_d;
            seg_q   <= seg_d;
        end
    end

    assign outValid   = valid_q[STAGES-1];
    assign count      = count_q;
    assign normalized = norm_q;
    assign allMatch   = all_q;

endmodule

// File: tb/tb_leading_zero_normalizer.sv
// ============================================================================
// tb_leading_zero_normalizer
//
// Directed bench for two instances: a 24-bit, 2-stage instance that checks the
// count/shift function and reset behaviour, and a 7-bit, 3-stage instance that
// checks odd widths and the stall/backpressure behaviour of the pipeline.
// ============================================================================
module tb_leading_zero_normalizer;

    logic clock  = 1'b0;
    logic resetN = 1'b0;

    always #5 clock = ~clock;

    // Instance A: WIDTH=24, STAGES=2
    logic        a_in_valid;
    logic        a_in_ready;
    logic [23:0] a_operand;
    logic [1:0]  a_mode;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [5:0]  a_count;
    logic [23:0] a_norm;
    logic        a_all;

    // Instance B: WIDTH=7, STAGES=3
    logic        b_in_valid;
    logic        b_in_ready;
    logic [6:0]  b_operand;
    logic [1:0]  b_mode;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [3:0]  b_count;
    logic [6:0]  b_norm;
    logic        b_all;

    int n_cmp = 0;
    int n_err = 0;

    leading_zero_normalizer #(.WIDTH(24), .STAGES(2)) u_dut_a (
        .clock      (clock),
        .resetN     (resetN),
        .inValid    (a_in_valid),
        .inReady    (a_in_ready),
        .operand    (a_operand),
        .mode       (a_mode),
        .outValid   (a_out_valid),
        .outReady   (a_out_ready),
        .count      (a_count),
        .normalized (a_norm),
        .allMatch   (a_all)
    );

    leading_zero_normalizer #(.WIDTH(7), .STAGES(3)) u_dut_b (
        .clock      (clock),
        .resetN     (resetN),
        .inValid    (b_in_valid),
        .inReady    (b_in_ready),
        .operand    (b_operand),
        .mode       (b_mode),
        .outValid   (b_out_valid),
        .outReady   (b_out_ready),
        .count      (b_count),
        .normalized (b_norm),
        .allMatch   (b_all)
    );

    // Count one comparison and report it if it differs.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: scan digit by digit and count the matching run.
    function automatic int ref_cnt(input logic [63:0] op, input int w, input logic [1:0] md);
        int   c;
        bit   run;
        logic b;
        logic m;
        c   = 0;
        run = 1'b1;
        for (int i = 0; i < w; i++) begin
            b = (md == 2'b10) ? op[i] : op[w-1-i];
            m = (md == 2'b01) ? b : ~b;
            if (run && m) c++;
            else run = 1'b0;
        end
        return c;
    endfunction

    // Expected {allMatch, normalized, count} for the 7-bit instance.
    function automatic logic [11:0] exp_b(input logic [6:0] op, input logic [1:0] md);
        int         c;
        logic [6:0] n;
        logic [3:0] c4;
        c  = ref_cnt({57'd0, op}, 7, md);
        c4 = 4'(c);
        if (md == 2'b10) n = op >> c;
        else             n = op << c;
        return {(c == 7), n, c4};
    endfunction

    // One transaction through A; entered at a negedge, result expected after 2 edges.
    task automatic run_a(input string tag, input logic [23:0] op, input logic [1:0] md,
                         input logic [5:0] ec, input logic [23:0] en, input logic ea);
        a_in_valid  = 1'b1;
        a_operand   = op;
        a_mode      = md;
        a_out_ready = 1'b1;
        #1 check_eq({tag, "_in_ready"}, a_in_ready, 1'b1);
        @(negedge clock);
        a_in_valid = 1'b0;
        a_operand  = ~op;       // disturb inputs: the captured copy must be used
        a_mode     = ~md;
        check_eq({tag, "_lat1"}, a_out_valid, 1'b0);
        @(negedge clock);
        check_eq({tag, "_valid"}, a_out_valid, 1'b1);
        check_eq({tag, "_count"}, a_count, ec);
        check_eq({tag, "_norm"},  a_norm,  en);
        check_eq({tag, "_all"},   a_all,   ea);
    endtask

    // One transaction through B; entered at a negedge, result expected after 3 edges.
    task automatic run_b(input string tag, input logic [6:0] op, input logic [1:0] md,
                         input logic [3:0] ec, input logic [6:0] en, input logic ea);
        b_in_valid  = 1'b1;
        b_operand   = op;
        b_mode      = md;
        b_out_ready = 1'b1;
        @(negedge clock);
        b_in_valid = 1'b0;
        b_mode     = ~md;
        check_eq({tag, "_lat1"}, b_out_valid, 1'b0);
        @(negedge clock);
        check_eq({tag, "_lat2"}, b_out_valid, 1'b0);
        @(negedge clock);
        check_eq({tag, "_valid"}, b_out_valid, 1'b1);
        check_eq({tag, "_count"}, b_count, ec);
        check_eq({tag, "_norm"},  b_norm,  en);
        check_eq({tag, "_all"},   b_all,   ea);
    endtask

    // Stream n operands into B. With stall_win, outReady is 0 on cycles 4..9,
    // otherwise it is random. Checks ready, in-order results and stall stability.
    task automatic stream_b(input string tag, input int n, input bit stall_win);
        logic [11:0] exp_q[$];
        logic [11:0] held;
        logic [11:0] obs;
        bit          held_valid;
        bit          ob;
        int          sent;
        int          got;
        int          in_flight;
        int          cyc;
        sent       = 0;
        got        = 0;
        in_flight  = 0;
        cyc        = 0;
        held_valid = 1'b0;
        held       = '0;
        while (got < n && cyc < 4000) begin
            @(negedge clock);
            if (stall_win) ob = !(cyc >= 4 && cyc <= 9);
            else           ob = ($urandom_range(2, 0) != 0);
            b_out_ready = ob;
            if (sent < n) begin
                b_in_valid = 1'b1;
                b_operand  = 7'($urandom_range(127, 0));
                b_mode     = 2'(sent);
            end else begin
                b_in_valid = 1'b0;
            end
            #1;
            check_eq({tag, "_in_ready"}, b_in_ready, ((in_flight < 3) || ob) ? 1'b1 : 1'b0);
            obs = {b_all, b_norm, b_count};
            if (held_valid) begin
                check_eq({tag, "_stall_valid"}, b_out_valid, 1'b1);
                check_eq({tag, "_stall_hold"},  obs, held);
            end
            if (in_flight == 0) check_eq({tag, "_idle_valid"}, b_out_valid, 1'b0);
            if (b_out_valid) begin
                if (ob) begin
                    if (exp_q.size() == 0) check_eq({tag, "_extra"}, 1'b1, 1'b0);
                    else                   check_eq({tag, "_result"}, obs, exp_q.pop_front());
                    got++;
                    in_flight--;
                    held_valid = 1'b0;
                end else begin
                    held_valid = 1'b1;
                    held       = obs;
                end
            end
            if (b_in_valid && b_in_ready) begin
                exp_q.push_back(exp_b(b_operand, b_mode));
                sent++;
                in_flight++;
            end
            cyc++;
        end
        b_in_valid = 1'b0;
        check_eq({tag, "_received"}, got, n);
        check_eq({tag, "_leftover"}, exp_q.size(), 0);
        @(negedge clock);
        check_eq({tag, "_drained"}, b_out_valid, 1'b0);
    endtask

    initial begin
        a_in_valid  = 1'b0;
        a_operand   = '0;
        a_mode      = 2'b00;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_operand   = '0;
        b_mode      = 2'b00;
        b_out_ready = 1'b0;

        // Reset state
        #12;
        check_eq("rst_a_valid", a_out_valid, 1'b0);
        check_eq("rst_a_ready", a_in_ready,  1'b0);
        check_eq("rst_a_count", a_count,     6'd0);
        check_eq("rst_a_norm",  a_norm,      24'd0);
        check_eq("rst_a_all",   a_all,       1'b0);
        check_eq("rst_b_valid", b_out_valid, 1'b0);
        check_eq("rst_b_ready", b_in_ready,  1'b0);

        // Release between edges; first accept on the very next edge
        @(negedge clock);
        resetN = 1'b1;
        run_a("a_lz_f000",   24'h00F000, 2'b00, 6'd8,  24'hF00000, 1'b0);
        run_a("a_lo_ffffff", 24'hFFFFFF, 2'b01, 6'd24, 24'h000000, 1'b1);
        run_a("a_lz_ffffff", 24'hFFFFFF, 2'b00, 6'd0,  24'hFFFFFF, 1'b0);
        run_a("a_lz_zero",   24'h000000, 2'b00, 6'd24, 24'h000000, 1'b1);
        run_a("a_lz_one",    24'h000001, 2'b00, 6'd23, 24'h800000, 1'b0);
        run_a("a_lo_f0f000", 24'hF0F000, 2'b01, 6'd4,  24'h0F0000, 1'b0);
        run_a("a_lo_7fffff", 24'h7FFFFF, 2'b01, 6'd0,  24'h7FFFFF, 1'b0);
        run_a("a_tz_f000",   24'h00F000, 2'b10, 6'd12, 24'h00000F, 1'b0);
        run_a("a_tz_msb",    24'h800000, 2'b10, 6'd23, 24'h000001, 1'b0);
        run_a("a_tz_lsb",    24'h000001, 2'b10, 6'd0,  24'h000001, 1'b0);
        run_a("a_tz_zero",   24'h000000, 2'b10, 6'd24, 24'h000000, 1'b1);
        run_a("a_m11_f000",  24'h00F000, 2'b11, 6'd8,  24'hF00000, 1'b0);

        // Back-to-back with a mode change between the two transactions
        a_in_valid  = 1'b1;
        a_operand   = 24'h00F000;
        a_mode      = 2'b00;
        a_out_ready = 1'b1;
        @(negedge clock);
        a_mode = 2'b10;
        @(negedge clock);
        a_in_valid = 1'b0;
        check_eq("a_b2b_v0",  a_out_valid, 1'b1);
        check_eq("a_b2b_c0",  a_count,     6'd8);
        check_eq("a_b2b_n0",  a_norm,      24'hF00000);
        @(negedge clock);
        check_eq("a_b2b_v1",  a_out_valid, 1'b1);
        check_eq("a_b2b_c1",  a_count,     6'd12);
        check_eq("a_b2b_n1",  a_norm,      24'h00000F);
        @(negedge clock);
        check_eq("a_b2b_end", a_out_valid, 1'b0);

        // Odd width, three stages
        run_b("b_tz_0101000", 7'b0101000, 2'b10, 4'd3, 7'b0000101, 1'b0);
        run_b("b_tz_zero",    7'b0000000, 2'b10, 4'd7, 7'b0000000, 1'b1);
        run_b("b_lz_one",     7'b0000001, 2'b00, 4'd6, 7'b1000000, 1'b0);
        run_b("b_lo_1111110", 7'b1111110, 2'b01, 4'd6, 7'b0000000, 1'b0);
        run_b("b_lo_ones",    7'b1111111, 2'b01, 4'd7, 7'b0000000, 1'b1);

        // Backpressure: stall window, then random outReady with rotating modes
        stream_b("b_stall", 10, 1'b1);
        stream_b("b_rand", 300, 1'b0);

        // Reset with two transactions in flight in A
        a_in_valid  = 1'b1;
        a_operand   = 24'h00F000;
        a_mode      = 2'b00;
        a_out_ready = 1'b0;
        @(negedge clock);
        a_operand = 24'h000001;
        @(negedge clock);
        a_in_valid = 1'b0;
        check_eq("mid_pre_valid", a_out_valid, 1'b1);
        check_eq("mid_pre_full",  a_in_ready,  1'b0);
        #2 resetN = 1'b0;
        #1;
        check_eq("mid_rst_valid", a_out_valid, 1'b0);
        check_eq("mid_rst_count", a_count,     6'd0);
        check_eq("mid_rst_norm",  a_norm,      24'd0);
        check_eq("mid_rst_ready", a_in_ready,  1'b0);
        @(negedge clock);
        resetN      = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("post_rst_stale", a_out_valid, 1'b0);
        end
        run_a("a_post_rst", 24'h000100, 2'b00, 6'd15, 24'h800000, 1'b0);
        @(negedge clock);
        check_eq("post_rst_end", a_out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
